// File: rtl/hf_reader_mode_seq.sv
// rtl/hf_reader_mode_seq.sv - HF reader minor-mode sequencer with frame alignment, TX->RX guard and RX timeout
// Optional feature: define HF_MODE_SEQ_JAM_EN to accept code 8 (SEND_JAM) as a TX-class mode.
module hf_reader_mode_seq #(
  parameter int          GUARD_CYCLES      = 128,
  parameter int          RX_TIMEOUT_FRAMES = 1023,
  parameter logic [3:0]  IDLE_MODE         = 4'd7
) (
  input  logic       ck_1356meg,
  input  logic       nrst,
  input  logic       req_valid,
  input  logic [3:0] req_mode,
  output logic       req_ready,
  input  logic       frame_strobe,
  output logic [3:0] minor_mode,
  output logic       rx_valid,
  output logic       timeout,
  output logic       req_err
);

  localparam int FW_RAW = $clog2(RX_TIMEOUT_FRAMES + 1);
  localparam int FW     = (FW_RAW < 1) ? 1 : FW_RAW;
  localparam int GW_RAW = $clog2(GUARD_CYCLES + 1);
  localparam int GW     = (GW_RAW < 1) ? 1 : GW_RAW;

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_GUARD, S_ACTIVE} state_t;
  typedef enum logic [1:0] {CLS_RX, CLS_TX, CLS_SNIFF, CLS_BAD} mode_class_t;

  function automatic mode_class_t classify(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2: classify = CLS_RX;
      4'd3, 4'd4:       classify = CLS_TX;
      4'd5, 4'd6, 4'd7: classify = CLS_SNIFF;
`ifdef HF_MODE_SEQ_JAM_EN
      4'd8:             classify = CLS_TX;
`else
      4'd8:             classify = CLS_BAD;
`endif
      default:          classify = CLS_BAD;
    endcase
  endfunction

  state_t          state;
  logic [3:0]      pend_mode;
  logic [GW-1:0]   guard_cnt;
  logic [FW-1:0]   frame_cnt;
  mode_class_t     req_cls;
  mode_class_t     cur_cls;
  mode_class_t     pend_cls;
  logic            accept;

  assign accept   = req_valid && req_ready;
  assign req_cls  = classify(req_mode);
  assign cur_cls  = classify(minor_mode);
  assign pend_cls = classify(pend_mode);

  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      state      <= S_IDLE;
      pend_mode  <= IDLE_MODE;
      guard_cnt  <= '0;
      frame_cnt  <= '0;
      minor_mode <= IDLE_MODE;
      req_ready  <= 1'b1;
      rx_valid   <= 1'b0;
      timeout    <= 1'b0;
      req_err    <= 1'b0;
    end else begin
      timeout <= 1'b0;
      req_err <= 1'b0;
      case (state)
        S_IDLE, S_ACTIVE: begin
          if (accept && req_cls == CLS_BAD) begin
            req_err <= 1'b1;
          end
          // A valid request wins over a coinciding expiry strobe.
          if (accept && req_cls != CLS_BAD) begin
            frame_cnt <= '0;
            if (!(state == S_ACTIVE && req_mode == minor_mode)) begin
              rx_valid <= 1'b0;
              if (req_cls == CLS_TX) begin
                minor_mode <= req_mode;
                state      <= S_ACTIVE;
              end else begin
                pend_mode <= req_mode;
                req_ready <= 1'b0;
                state     <= S_ALIGN;
              end
            end
          end else if (state == S_ACTIVE && frame_strobe && cur_cls != CLS_TX) begin
            if (cur_cls == CLS_RX && frame_cnt >= FW'(RX_TIMEOUT_FRAMES - 1)) begin
              timeout    <= 1'b1;
              minor_mode <= IDLE_MODE;
              rx_valid   <= 1'b0;
              frame_cnt  <= '0;
              state      <= S_IDLE;
            end else begin
              rx_valid <= 1'b1;
              if (cur_cls == CLS_RX) begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
        end
        S_ALIGN: begin
          if (frame_strobe) begin
            minor_mode <= pend_mode;
            frame_cnt  <= '0;
            // Carrier must settle after leaving a modulating mode for a receive mode.
            if (cur_cls == CLS_TX && pend_cls == CLS_RX) begin
              guard_cnt <= '0;
              state     <= S_GUARD;
            end else begin
              req_ready <= 1'b1;
              state     <= S_ACTIVE;
            end
          end
        end
        S_GUARD: begin
          if (guard_cnt >= GW'(GUARD_CYCLES - 1)) begin
            req_ready <= 1'b1;
            state     <= S_ACTIVE;
          end else begin
            guard_cnt <= guard_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hf_reader_mode_seq.sv
// tb/tb_hf_reader_mode_seq.sv - directed vector bench for hf_reader_mode_seq
module tb_hf_reader_mode_seq;

  logic       ck_1356meg = 1'b0;
  logic       nrst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_mode = 4'd0;
  logic       frame_strobe = 1'b0;
  logic       req_ready;
  logic [3:0] minor_mode;
  logic       rx_valid;
  logic       timeout;
  logic       req_err;

  hf_reader_mode_seq dut (
    .ck_1356meg   (ck_1356meg),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_mode     (req_mode),
    .req_ready    (req_ready),
    .frame_strobe (frame_strobe),
    .minor_mode   (minor_mode),
    .rx_valid     (rx_valid),
    .timeout      (timeout),
    .req_err      (req_err)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  typedef struct {
    logic       rv;
    logic [3:0] mode;
    logic       st;
    logic [3:0] e_mode;
    logic       e_ready;
    logic       e_rxv;
    logic       e_err;
  } vec_t;

  vec_t tbl[16];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   strobe_per = 64;
  bit   gen_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ck_1356meg);
    #1;
    cyc++;
    if (gen_en) frame_strobe = (cyc % strobe_per == 0);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_mode(input logic [3:0] m, input string name);
    for (int k = 0; k < 200 && minor_mode !== m; k++) tick();
    check(name, minor_mode, m);
  endtask

  task automatic count_strobes(input int target, output int n, output int pulses, output int n_at);
    logic prev;
    n = 0;
    pulses = 0;
    n_at = -1;
    for (int k = 0; k < target * strobe_per + 64 && n < target; k++) begin
      prev = frame_strobe;
      tick();
      if (prev) n++;
      if (timeout) begin
        pulses++;
        n_at = n;
      end
    end
    check("strobe_budget", n[15:0], target[15:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, pulses, n_at, rx_hi, bad_hold;

    tbl[0]  = '{1'b1, 4'd3,  1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd12, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 4'd0,  1'b0, 4'd3, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'd4,  1'b0, 4'd4, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'd6,  1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'd12, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd0,  1'b1, 4'd6, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'd0,  1'b0, 4'd6, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 4'd6, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 4'd6,  1'b0, 4'd6, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 4'd2,  1'b0, 4'd6, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'd0,  1'b1, 4'd2, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 4'd0,  1'b1, 4'd2, 1'b1, 1'b1, 1'b0};
`ifdef HF_MODE_SEQ_JAM_EN
    tbl[13] = '{1'b1, 4'd8,  1'b0, 4'd8, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 4'd15, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
`else
    tbl[13] = '{1'b1, 4'd8,  1'b0, 4'd2, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 4'd15, 1'b0, 4'd2, 1'b1, 1'b1, 1'b1};
`endif
    tbl[15] = '{1'b1, 4'd3,  1'b0, 4'd3, 1'b1, 1'b0, 1'b0};

    // Reset values
    nrst = 1'b0;
    repeat (3) tick();
    check("rst_minor", minor_mode, 4'd7);
    check("rst_ready", req_ready, 1'b1);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_err", req_err, 1'b0);
    nrst = 1'b1;
    tick();

    // Cycle-by-cycle vectors
    for (int i = 0; i < 16; i++) begin
      req_valid = tbl[i].rv;
      req_mode = tbl[i].mode;
      frame_strobe = tbl[i].st;
      tick();
      check($sformatf("vec%0d_mode", i), minor_mode, tbl[i].e_mode);
      check($sformatf("vec%0d_ready", i), req_ready, tbl[i].e_ready);
      check($sformatf("vec%0d_rxv", i), rx_valid, tbl[i].e_rxv);
      check($sformatf("vec%0d_err", i), req_err, tbl[i].e_err);
      check($sformatf("vec%0d_timeout", i), timeout, 1'b0);
    end
    req_valid = 1'b0;
    frame_strobe = 1'b0;

    // Request 1 at cycle 10, strobes every 64 clocks
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    cyc = 0;
    gen_en = 1'b1;
    strobe_per = 64;
    run_to(10);
    req_valid = 1'b1;
    req_mode = 4'd1;
    tick();
    req_valid = 1'b0;
    check("align_ready", req_ready, 1'b0);
    check("align_minor", minor_mode, 4'd7);
    run_to(64);
    check("align_hold64", minor_mode, 4'd7);
    tick();
    check("rx1_minor65", minor_mode, 4'd1);
    check("rx1_ready65", req_ready, 1'b1);
    check("rx1_rxv65", rx_valid, 1'b0);
    run_to(128);
    check("rx1_rxv128", rx_valid, 1'b0);
    tick();
    check("rx1_rxv129", rx_valid, 1'b1);

    // TX mode 4, then RX mode 0 through the guard interval
    req_valid = 1'b1;
    req_mode = 4'd4;
    tick();
    check("tx4_minor", minor_mode, 4'd4);
    check("tx4_rxv", rx_valid, 1'b0);
    req_mode = 4'd0;
    tick();
    req_valid = 1'b0;
    check("rx0_align_ready", req_ready, 1'b0);
    run_to(192);
    check("rx0_hold192", minor_mode, 4'd4);
    tick();
    check("rx0_minor193", minor_mode, 4'd0);
    check("guard_ready193", req_ready, 1'b0);
    rx_hi = 0;
    while (cyc < 320) begin
      rx_hi += int'(rx_valid);
      tick();
    end
    check("guard_ready320", req_ready, 1'b0);
    tick();
    check("active_ready321", req_ready, 1'b1);
    while (cyc < 384) begin
      rx_hi += int'(rx_valid);
      tick();
    end
    rx_hi += int'(rx_valid);
    check("guard_rxv_low", rx_hi[15:0], 16'd0);
    tick();
    check("rx0_rxv385", rx_valid, 1'b1);

    // RX mode 1 held for 1023 strobes
    strobe_per = 4;
    req_valid = 1'b1;
    req_mode = 4'd1;
    tick();
    req_valid = 1'b0;
    wait_mode(4'd1, "to_enter_mode1");
    count_strobes(1023, n, pulses, n_at);
    check("to_pulses", pulses[15:0], 16'd1);
    check("to_at_strobe", n_at[15:0], 16'd1023);
    check("to_minor", minor_mode, 4'd7);
    check("to_ready", req_ready, 1'b1);
    check("to_rxv", rx_valid, 1'b0);
    tick();
    check("to_one_cycle", timeout, 1'b0);

    // Requests landing on the expiry strobe
    req_valid = 1'b1;
    req_mode = 4'd1;
    tick();
    req_valid = 1'b0;
    wait_mode(4'd1, "pri_enter_mode1");
    count_strobes(1022, n, pulses, n_at);
    check("pri_no_early_to", pulses[15:0], 16'd0);
    for (int k = 0; k < 8 && !frame_strobe; k++) tick();
    req_valid = 1'b1;
    req_mode = 4'd1;
    tick();
    req_valid = 1'b0;
    check("pri_same_timeout", timeout, 1'b0);
    check("pri_same_minor", minor_mode, 4'd1);
    check("pri_same_rxv", rx_valid, 1'b1);
    count_strobes(1022, n, pulses, n_at);
    check("pri_cnt_cleared", pulses[15:0], 16'd0);
    for (int k = 0; k < 8 && !frame_strobe; k++) tick();
    req_valid = 1'b1;
    req_mode = 4'd3;
    tick();
    req_valid = 1'b0;
    check("pri_tx_timeout", timeout, 1'b0);
    check("pri_tx_minor", minor_mode, 4'd3);
    tick();
    check("pri_tx_after", timeout, 1'b0);

    // Reset during GUARD
    req_valid = 1'b1;
    req_mode = 4'd0;
    tick();
    req_valid = 1'b0;
    wait_mode(4'd0, "grd_enter_mode0");
    check("grd_ready", req_ready, 1'b0);
    repeat (5) tick();
    nrst = 1'b0;
    #1;
    check("grd_rst_minor", minor_mode, 4'd7);
    check("grd_rst_ready", req_ready, 1'b1);
    check("grd_rst_rxv", rx_valid, 1'b0);
    repeat (2) tick();
    nrst = 1'b1;
    bad_hold = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (minor_mode !== 4'd7 || req_ready !== 1'b1 || rx_valid !== 1'b0) bad_hold++;
    end
    check("no_replay", bad_hold[15:0], 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
